// File: rtl/kim_pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait freeze
// with a timeout error state and a saturating stall counter.
module kim_pipe_ctrl #(
    parameter int unsigned MIPS_REGISTER_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT              = 255,
    parameter int unsigned STALL_CNT_WIDTH          = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [MIPS_REGISTER_ADDR_WIDTH-1:0] IF_ID_Rs,
    input  logic [MIPS_REGISTER_ADDR_WIDTH-1:0] IF_ID_Rt,
    input  logic                                IF_ID_uses_Rt,
    input  logic                                ID_EX_MemRead,
    input  logic [MIPS_REGISTER_ADDR_WIDTH-1:0] ID_EX_Rt,
    input  logic                                branch_taken,
    input  logic                                dmem_req,
    input  logic                                dmem_ready,
    output logic                                pc_write,
    output logic                                if_id_write,
    output logic                                id_ex_write,
    output logic                                ex_mem_write,
    output logic                                mem_wb_write,
    output logic                                if_id_flush,
    output logic                                id_ex_flush,
    output logic                                mem_timeout,
    output logic [STALL_CNT_WIDTH-1:0]          stall_count
);

    // The wait counter only needs to reach MEM_TIMEOUT-1 before the error transition.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] LastWait = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [WaitW-1:0]           wait_cnt_q, wait_cnt_d;
    logic                       mem_timeout_q, mem_timeout_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic freeze;
    logic load_use;
    logic bubble;
    logic stall_inc;

    always_comb begin
        unique case (state_q)
            StRun:     freeze = dmem_req & ~dmem_ready;
            StMemWait: freeze = ~dmem_ready;
            StErr:     freeze = 1'b1;
            default:   freeze = 1'b0;
        endcase
    end

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_uses_Rt && (ID_EX_Rt == IF_ID_Rt)));

    assign bubble    = load_use & ~branch_taken & ~freeze;
    assign stall_inc = freeze | bubble;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_count_d = stall_count_q;

        unique case (state_q)
            StRun: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                end else if (wait_cnt_q == LastWait) begin
                    state_d       = StErr;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StErr: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (stall_inc && (stall_count_q != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Reset gates the enables so the pipeline sees idle values even if reset lands mid-wait.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (reset_n) begin
            if (freeze) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
            end else if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_kim_pipe_ctrl.sv
// Bench for kim_pipe_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model of the hazard rules.
module tb_kim_pipe_ctrl;

    localparam int AW   = 5;
    localparam int TO   = 4;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
    logic          uses_rt = 1'b0, mem_read = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

    logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic          if_id_flush, id_ex_flush, mem_timeout;
    logic [SW-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kim_pipe_ctrl #(
        .MIPS_REGISTER_ADDR_WIDTH(AW),
        .MEM_TIMEOUT(TO),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .IF_ID_Rs(if_id_rs),
        .IF_ID_Rt(if_id_rt),
        .IF_ID_uses_Rt(uses_rt),
        .ID_EX_MemRead(mem_read),
        .ID_EX_Rt(id_ex_rt),
        .branch_taken(br),
        .dmem_req(req),
        .dmem_ready(rdy),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout),
        .stall_count(stall_count)
    );

    // Model: flags for "waiting on memory" and "dead", plus plain integer counters.
    bit m_waiting = 1'b0;
    bit m_dead    = 1'b0;
    int m_wait_cycles = 0;
    int m_stalls  = 0;

    logic       m_hazard, m_frozen;
    logic [7:0] exp_vec;
    logic [7:0] dut_vec;

    assign dut_vec = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                      if_id_flush, id_ex_flush, mem_timeout};

    always_comb begin
        m_hazard = mem_read && (id_ex_rt != 0) &&
                   (id_ex_rt == if_id_rs || (uses_rt && id_ex_rt == if_id_rt));
        m_frozen = m_dead || (m_waiting ? !rdy : (req && !rdy));
        if (!reset_n)       exp_vec = 8'b11111_00_0;
        else if (m_frozen)  exp_vec = {5'b00000, 2'b00, m_dead};
        else if (br)        exp_vec = 8'b11111_11_0;
        else if (m_hazard)  exp_vec = 8'b00111_01_0;
        else                exp_vec = 8'b11111_00_0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_waiting     <= 1'b0;
            m_dead        <= 1'b0;
            m_wait_cycles <= 0;
            m_stalls      <= 0;
        end else begin
            if ((m_frozen || (m_hazard && !br)) && m_stalls < SMAX) m_stalls <= m_stalls + 1;
            if (!m_dead) begin
                if (m_waiting) begin
                    if (rdy) begin
                        m_waiting <= 1'b0;
                    end else if (m_wait_cycles + 1 >= TO) begin
                        m_waiting <= 1'b0;
                        m_dead    <= 1'b1;
                    end else begin
                        m_wait_cycles <= m_wait_cycles + 1;
                    end
                end else if (req && !rdy) begin
                    m_waiting     <= 1'b1;
                    m_wait_cycles <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk("outputs{pc,ifid,idex,exmem,memwb,iff,idf,tmo}", int'(dut_vec), int'(exp_vec));
        chk("stall_count", int'(stall_count), m_stalls);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input int mr, input int ert, input int rs, input int rt, input int u,
                       input int b, input int rq, input int rd);
        mem_read = mr[0];
        id_ex_rt = AW'(ert);
        if_id_rs = AW'(rs);
        if_id_rt = AW'(rt);
        uses_rt  = u[0];
        br       = b[0];
        req      = rq[0];
        rdy      = rd[0];
    endtask

    initial begin
        // Reset values
        set(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset pc_write", int'(pc_write), 1);
        chk("reset mem_timeout", int'(mem_timeout), 0);
        chk("reset stall_count", int'(stall_count), 0);
        next();
        reset_n = 1'b1;

        // Load-use on Rs
        set(1, 8, 8, 0, 0, 0, 0, 0);
        settle();
        chk("lu pc_write", int'(pc_write), 0);
        chk("lu if_id_write", int'(if_id_write), 0);
        chk("lu id_ex_flush", int'(id_ex_flush), 1);
        chk("lu ex_mem_write", int'(ex_mem_write), 1);
        next();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("after lu pc_write", int'(pc_write), 1);
        chk("after lu stall_count", int'(stall_count), 1);
        next();

        // Register 0 never hazards; Rt matters only when used
        set(1, 0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("r0 pc_write", int'(pc_write), 1);
        chk("r0 id_ex_flush", int'(id_ex_flush), 0);
        next();
        set(1, 5, 1, 5, 0, 0, 0, 0);
        settle();
        chk("rt unused pc_write", int'(pc_write), 1);
        chk("rt unused stall_count", int'(stall_count), 1);
        next();
        set(1, 5, 1, 5, 1, 0, 0, 0);
        settle();
        chk("rt used pc_write", int'(pc_write), 0);
        next();

        // Memory wait: three frozen cycles then ready
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 0, 0, 0, 0, 1, 0);
            settle();
            chk("memwait pc_write", int'(pc_write), 0);
            chk("memwait mem_wb_write", int'(mem_wb_write), 0);
            next();
        end
        set(0, 0, 0, 0, 0, 0, 1, 1);
        settle();
        chk("ready pc_write", int'(pc_write), 1);
        next();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("back in run pc_write", int'(pc_write), 1);
        chk("memwait stall_count", int'(stall_count), 5);
        next();

        // Branch beats load-use; freeze beats branch
        set(1, 8, 8, 0, 0, 1, 0, 0);
        settle();
        chk("br if_id_flush", int'(if_id_flush), 1);
        chk("br id_ex_flush", int'(id_ex_flush), 1);
        chk("br pc_write", int'(pc_write), 1);
        next();
        for (int i = 0; i < 2; i++) begin
            set(1, 8, 8, 0, 0, 1, 1, 0);
            settle();
            chk("frozen br if_id_flush", int'(if_id_flush), 0);
            chk("frozen br pc_write", int'(pc_write), 0);
            next();
        end
        set(1, 8, 8, 0, 0, 1, 1, 1);
        settle();
        chk("unfrozen br if_id_flush", int'(if_id_flush), 1);
        chk("unfrozen br stall_count", int'(stall_count), 7);
        next();

        // Timeout: one RUN cycle plus four MEM_WAIT cycles, then ERR
        for (int i = 0; i < 5; i++) begin
            set(0, 0, 0, 0, 0, 0, 1, 0);
            settle();
            chk("pre-timeout mem_timeout", int'(mem_timeout), 0);
            next();
        end
        set(0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("err mem_timeout", int'(mem_timeout), 1);
        chk("err pc_write", int'(pc_write), 0);
        chk("err stall_count", int'(stall_count), 12);
        next();
        for (int i = 0; i < 19; i++) begin
            set(0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
            settle();
            next();
        end
        chk("saturated stall_count", int'(stall_count), 15);
        chk("err ignores ready", int'(pc_write), 0);

        // Reset asserted in ERR with a stalled request pending
        set(1, 8, 8, 0, 0, 1, 1, 0);
        reset_n = 1'b0;
        settle();
        chk("rst in err mem_timeout", int'(mem_timeout), 0);
        chk("rst in err if_id_flush", int'(if_id_flush), 0);
        chk("rst in err pc_write", int'(pc_write), 1);
        chk("rst in err stall_count", int'(stall_count), 0);
        next();
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 1));
            reset_n = ($urandom_range(0, 79) != 0);
            settle();
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kim_pipe_ctrl.md
KIM_PIPE_CTRL -- requirements
Module: kim_pipe_ctrl

Interface
REQ-001 SHALL have parameter MIPS_REGISTER_ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum dmem wait cycles before error.
REQ-003 SHALL have parameter STALL_CNT_WIDTH, default 16, stall counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk and reset_n are listed first.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
IF_ID_Rs  in  ADDR  Rs of the instruction in ID.
IF_ID_Rt  in  ADDR  Rt of the instruction in ID.
IF_ID_uses_Rt  in  1  the ID instruction reads Rt.
ID_EX_MemRead  in  1  the EX instruction is a load.
ID_EX_Rt  in  ADDR  load destination in EX.
branch_taken  in  1  branch or jump resolved taken in EX.
dmem_req  in  1  MEM stage is accessing data memory.
dmem_ready  in  1  data memory completes the access this cycle.
pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline register enables.
if_id_flush, id_ex_flush  out  1 each  bubble insertion.
mem_timeout  out  1  sticky error flag.
stall_count  out  STALL_CNT_WIDTH  saturating count of stall cycles.

Function
REQ-006 SHALL implement FSM states RUN, MEM_WAIT and ERR; the reset state is RUN.
REQ-007 SHALL define freeze = (RUN & dmem_req & !dmem_ready) | (MEM_WAIT & !dmem_ready) | ERR.
REQ-008 SHALL drive all five write enables to 0 and both flushes to 0 while freeze=1 (combinational, same cycle).
REQ-009 SHALL transition RUN->MEM_WAIT when dmem_req=1 and dmem_ready=0; with dmem_req=1 and dmem_ready=1 it SHALL stay in RUN with no stall.
REQ-010 SHALL, in MEM_WAIT with dmem_ready=1, unfreeze in that same cycle and return to RUN on the next edge.
REQ-011 SHALL count consecutive MEM_WAIT cycles in a wait counter that clears on entry to MEM_WAIT; when the counter reaches MEM_TIMEOUT while dmem_ready=0, the FSM SHALL go to ERR and set mem_timeout.
REQ-012 SHALL remain in ERR, frozen with mem_timeout=1, until reset; dmem_ready SHALL be ignored in ERR.
REQ-013 SHALL define load_use = ID_EX_MemRead & (ID_EX_Rt!=0) & ((ID_EX_Rt==IF_ID_Rs) | (IF_ID_uses_Rt & ID_EX_Rt==IF_ID_Rt)).
REQ-014 SHALL, on load_use with freeze=0 and branch_taken=0, drive pc_write=0, if_id_write=0 and id_ex_flush=1 for exactly that cycle; all other enables SHALL be 1.
REQ-015 SHALL, on branch_taken with freeze=0, drive if_id_flush=1 and id_ex_flush=1 with all enables 1; branch_taken SHALL override load_use.
REQ-016 SHALL give freeze priority over branch_taken and load_use; a branch_taken held during a freeze SHALL take effect in the first unfrozen cycle.
REQ-017 SHALL, with no event, drive all enables=1 and all flushes=0.
REQ-018 SHALL increment stall_count by 1 on each edge where freeze=1 or a load-use bubble is inserted, saturating at all-ones without wrap; branch flushes SHALL NOT count.
REQ-019 SHALL never treat register 0 as a load-use hazard.

Reset
REQ-020 SHALL, on reset_n=0, asynchronously set state=RUN, wait counter=0, mem_timeout=0 and stall_count=0.
REQ-021 SHALL drive outputs to the REQ-017 values with mem_timeout=0 during reset, including when reset is asserted mid MEM_WAIT or in ERR.

Verification
REQ-022 Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_count=1.
REQ-023 Register 0: ID_EX_Rt=0, IF_ID_Rs=0, MemRead=1 -> no stall, stall_count unchanged.
REQ-024 Mem wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles, unfrozen on the ready cycle, state RUN next cycle, stall_count=3.
REQ-025 Priority: branch_taken=1 and load_use together -> if_id_flush=1, id_ex_flush=1, pc_write=1; the same inputs during a freeze -> no flush until dmem_ready.
REQ-026 Timeout: MEM_TIMEOUT=4, dmem_ready stuck at 0 -> ERR and mem_timeout=1 after 4 MEM_WAIT cycles, frozen thereafter; a later dmem_ready=1 has no effect; reset_n=0 clears to RUN with mem_timeout=0.
REQ-027 Saturation: STALL_CNT_WIDTH=4, 20 frozen cycles -> stall_count holds 15.
